// File: rtl/matrix_transpose_engine_pkg.sv
// rtl/matrix_transpose_engine_pkg.sv - shared constants and FSM state type for the transpose engine
package transpose_pkg;

  localparam int DIM    = 16;
  localparam int WIDTH  = 32;
  localparam int IDX_W  = $clog2(DIM);
  localparam int ADDR_W = 2 * IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_transpose_engine_if.sv
// rtl/matrix_transpose_engine_if.sv - A read port and C write port bundle
interface matrix_transpose_engine_if #(
  parameter int DIM   = 16,
  parameter int WIDTH = 32
);
  localparam int ADDR_W = 2 * $clog2(DIM);

  logic [WIDTH-1:0]  Ai_p0_rd_data;
  logic              Ai_p0_addr_en;
  logic [ADDR_W-1:0] Ai_p0_addr_data;
  logic              Ai_p0_rd_en;
  logic              Co_p0_addr_en;
  logic [ADDR_W-1:0] Co_p0_addr_data;
  logic              Co_p0_wr_en;
  logic [WIDTH-1:0]  Co_p0_wr_data;

  // engine side
  modport master (
    input  Ai_p0_rd_data,
    output Ai_p0_addr_en, Ai_p0_addr_data, Ai_p0_rd_en,
    output Co_p0_addr_en, Co_p0_addr_data, Co_p0_wr_en, Co_p0_wr_data
  );

  // memory side
  modport slave (
    output Ai_p0_rd_data,
    input  Ai_p0_addr_en, Ai_p0_addr_data, Ai_p0_rd_en,
    input  Co_p0_addr_en, Co_p0_addr_data, Co_p0_wr_en, Co_p0_wr_data
  );

endinterface

// File: rtl/matrix_transpose_engine_idx_counter.sv
// rtl/matrix_transpose_engine_idx_counter.sv - saturating element counter split into row/column indices
module transpose_idx_counter
  import transpose_pkg::*;
#(
  parameter int  DIM   = transpose_pkg::DIM,
  localparam int CW    = $clog2(DIM),
  localparam int AW    = 2 * CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_i,
  output logic [CW-1:0] o_j,
  output logic [AW-1:0] o_swap,
  output logic          o_tc
);

  logic [AW-1:0] r_cnt;
  logic          w_tc;

  assign w_tc = (r_cnt == {AW{1'b1}});

  // count one element per enabled cycle, holding at the last element instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // row index is the high half, column index the low half, so j moves fastest
  assign o_i    = r_cnt[AW-1:CW];
  assign o_j    = r_cnt[CW-1:0];
  assign o_swap = {r_cnt[CW-1:0], r_cnt[AW-1:CW]};
  assign o_tc   = w_tc;

endmodule

// File: rtl/matrix_transpose_engine.sv
// rtl/matrix_transpose_engine.sv - streaming DIM x DIM transpose between a read port and a write port
module matrix_transpose_engine
  import transpose_pkg::*;
#(
  parameter int  DIM    = transpose_pkg::DIM,
  parameter int  WIDTH  = transpose_pkg::WIDTH,
  localparam int CW     = $clog2(DIM),
  localparam int AW     = 2 * CW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       t,
  matrix_transpose_engine_if.master  mem,
  output logic                       done
);

  state_t          r_state;
  state_t          w_next;
  logic            w_run;
  logic [CW-1:0]   w_i;
  logic [CW-1:0]   w_j;
  logic [AW-1:0]   w_swap;
  logic            w_tc;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [WIDTH-1:0] w_rd_data;

  // state register; reset aborts any run in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state: start only from IDLE, leave RUN once the last read has been issued
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (t) w_next = RUN;
      RUN:     if (w_tc) w_next = DRAIN;
      DRAIN:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_run = (r_state == RUN);

  transpose_idx_counter #(
    .DIM (DIM)
  ) u_idx (
    .clk    (clk),
    .rst_n  (rst),
    .i_clr  (!w_run),
    .i_en   (w_run),
    .o_i    (w_i),
    .o_j    (w_j),
    .o_swap (w_swap),
    .o_tc   (w_tc)
  );

  // write stage trails the read by one cycle, matching the memory read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
    end else begin
      r_wr_en   <= w_run;
      r_wr_addr <= w_run ? w_swap : '0;
    end
  end

  assign mem.Ai_p0_rd_en     = w_run;
  assign mem.Ai_p0_addr_en   = w_run;
  assign mem.Ai_p0_addr_data = w_run ? {w_i, w_j} : '0;

  // read data lands in the same cycle it is written, so it passes straight through
  assign w_rd_data           = mem.Ai_p0_rd_data;
  assign mem.Co_p0_wr_data   = w_rd_data;
  assign mem.Co_p0_wr_en     = r_wr_en;
  assign mem.Co_p0_addr_en   = r_wr_en;
  assign mem.Co_p0_addr_data = r_wr_addr;

  assign done = (r_state == DONE);

endmodule

// File: tb/tb_matrix_transpose_engine.sv
// tb/tb_matrix_transpose_engine.sv - scoreboard bench for the transpose engine
module tb_matrix_transpose_engine;

  logic clk;
  logic rst;
  logic t;
  logic done;

  matrix_transpose_engine_if #(.DIM(16), .WIDTH(32)) mem_if ();

  matrix_transpose_engine #(.DIM(16), .WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .t    (t),
    .mem  (mem_if),
    .done (done)
  );

  logic [31:0] a_mem [256];
  logic [31:0] c_mem [256];
  logic [31:0] orig  [256];
  logic [7:0]  sb_addr [$];
  logic [31:0] sb_data [$];
  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // one-cycle-latency source memory and destination memory
  always @(posedge clk) begin
    if (mem_if.Ai_p0_rd_en) mem_if.Ai_p0_rd_data <= a_mem[mem_if.Ai_p0_addr_data];
    if (mem_if.Co_p0_wr_en) c_mem[mem_if.Co_p0_addr_data] <= mem_if.Co_p0_wr_data;
  end

  // write-stream scoreboard
  always @(negedge clk) begin
    if (rst && mem_if.Co_p0_wr_en) begin
      wr_count++;
      n_checks++;
      if (sb_addr.size() == 0) begin
        $display("FAIL sb_unexpected_write addr=%h data=%h required=no write",
                 mem_if.Co_p0_addr_data, mem_if.Co_p0_wr_data);
      end else begin
        logic [7:0]  ea;
        logic [31:0] ed;
        ea = sb_addr.pop_front();
        ed = sb_data.pop_front();
        if ({mem_if.Co_p0_addr_en, mem_if.Co_p0_addr_data, mem_if.Co_p0_wr_data} !== {1'b1, ea, ed})
          $display("FAIL sb_write got addr_en=%b addr=%h data=%h required addr_en=1 addr=%h data=%h",
                   mem_if.Co_p0_addr_en, mem_if.Co_p0_addr_data, mem_if.Co_p0_wr_data, ea, ed);
        else
          n_pass++;
      end
    end
  end

  function automatic logic [7:0] swp(input logic [7:0] n);
    return {n[3:0], n[7:4]};
  endfunction

  task automatic push_expected();
    for (int n = 0; n < 256; n++) begin
      sb_addr.push_back(swp(n[7:0]));
      sb_data.push_back(a_mem[n]);
    end
  endtask

  task automatic fill_c(input logic [31:0] v);
    for (int n = 0; n < 256; n++) c_mem[n] = v;
  endtask

  task automatic run_full(output bit got_done);
    got_done = 1'b0;
    @(negedge clk); t = 1'b1;
    @(negedge clk); t = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (done) got_done = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    t   = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_if.Ai_p0_rd_en, mem_if.Ai_p0_addr_en, mem_if.Co_p0_wr_en, mem_if.Co_p0_addr_en, done} !== 5'b0)
      $display("FAIL reset_strobes got=%b required=00000",
               {mem_if.Ai_p0_rd_en, mem_if.Ai_p0_addr_en, mem_if.Co_p0_wr_en, mem_if.Co_p0_addr_en, done});
    else n_pass++;
    n_checks++;
    if ({mem_if.Ai_p0_addr_data, mem_if.Co_p0_addr_data} !== 16'h0)
      $display("FAIL reset_addrs got=%h required=0000", {mem_if.Ai_p0_addr_data, mem_if.Co_p0_addr_data});
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_if.Ai_p0_rd_en, mem_if.Co_p0_wr_en, done} !== 3'b0)
      $display("FAIL idle_after_reset got=%b required=000", {mem_if.Ai_p0_rd_en, mem_if.Co_p0_wr_en, done});
    else n_pass++;
  endtask

  task automatic test_identity_timing();
    logic [20:0] obs, exp;
    for (int n = 0; n < 256; n++) a_mem[n] = n;
    fill_c(32'hDEADBEEF);
    push_expected();
    @(negedge clk); t = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k == 1) t = 1'b0;
      exp = {(k <= 256) ? 2'b11 : 2'b00,
             (k <= 256) ? 8'(k - 1) : 8'h00,
             (k >= 2 && k <= 257) ? 2'b11 : 2'b00,
             (k >= 2 && k <= 257) ? swp(8'(k - 2)) : 8'h00,
             (k == 258)};
      obs = {mem_if.Ai_p0_rd_en, mem_if.Ai_p0_addr_en,
             mem_if.Ai_p0_rd_en ? mem_if.Ai_p0_addr_data : 8'h00,
             mem_if.Co_p0_wr_en, mem_if.Co_p0_addr_en,
             mem_if.Co_p0_wr_en ? mem_if.Co_p0_addr_data : 8'h00,
             done};
      n_checks++;
      if (obs !== exp) $display("FAIL timing_cycle_%0d got=%h required=%h", k, obs, exp);
      else n_pass++;
    end
    n_checks++;
    if ({c_mem[1], c_mem[16], c_mem[255], c_mem[0]} !== {32'd16, 32'd1, 32'd255, 32'd0})
      $display("FAIL identity_corners got=%h %h %h %h required=10 1 ff 0", c_mem[1], c_mem[16], c_mem[255], c_mem[0]);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        n_checks++;
        if (c_mem[j*16+i] !== 32'(i*16+j))
          $display("FAIL identity_c_%0d got=%h required=%h", j*16+i, c_mem[j*16+i], 32'(i*16+j));
        else n_pass++;
      end
    end
    n_checks++;
    if (sb_addr.size() != 0) $display("FAIL identity_sb_left got=%0d required=0", sb_addr.size());
    else n_pass++;
  endtask

  task automatic test_retrigger();
    int dones = 0;
    int base;
    for (int n = 0; n < 256; n++) a_mem[n] = $urandom;
    push_expected();
    base = wr_count;
    @(negedge clk); t = 1'b1;
    for (int c = 1; c <= 280; c++) begin
      @(negedge clk);
      if (c == 10)  t = 1'b0;
      if (c == 100) t = 1'b1;
      if (c == 101) t = 1'b0;
      if (done) dones++;
    end
    n_checks++;
    if (wr_count - base != 256) $display("FAIL retrigger_writes got=%0d required=256", wr_count - base);
    else n_pass++;
    n_checks++;
    if (dones != 1) $display("FAIL retrigger_dones got=%0d required=1", dones);
    else n_pass++;
    n_checks++;
    if (sb_addr.size() != 0) $display("FAIL retrigger_sb_left got=%0d required=0", sb_addr.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    for (int n = 0; n < 256; n++) a_mem[n] = n;
    push_expected();
    @(negedge clk); t = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (c == 1) t = 1'b0;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 258) begin
        for (int n = 0; n < 256; n++) a_mem[n] = 32'hA5A50000 + n;
        push_expected();
      end
      if (c == 259) t = 1'b1;
      if (c == 260) t = 1'b0;
    end
    n_checks++;
    if (d1 != 258 || d2 != 517) $display("FAIL b2b_done_cycles got=%0d,%0d required=258,517", d1, d2);
    else n_pass++;
    n_checks++;
    if (c_mem[8'h12] !== 32'hA5A50021) $display("FAIL b2b_c12 got=%h required=a5a50021", c_mem[8'h12]);
    else n_pass++;
    for (int n = 0; n < 256; n++) begin
      n_checks++;
      if (c_mem[swp(n[7:0])] !== a_mem[n])
        $display("FAIL b2b_c_%0d got=%h required=%h", swp(n[7:0]), c_mem[swp(n[7:0])], a_mem[n]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    int  base;
    bit  quiet = 1'b1;
    bit  got_done;
    for (int n = 0; n < 256; n++) a_mem[n] = 32'h50000000 + n;
    fill_c(32'hDEADBEEF);
    push_expected();
    @(negedge clk); t = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) t = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_if.Ai_p0_rd_en, mem_if.Co_p0_wr_en, done} !== 3'b000)
      $display("FAIL async_reset_strobes got=%b required=000", {mem_if.Ai_p0_rd_en, mem_if.Co_p0_wr_en, done});
    else n_pass++;
    sb_addr.delete();
    sb_data.delete();
    base = wr_count;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done || mem_if.Ai_p0_rd_en || mem_if.Co_p0_wr_en) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet || wr_count != base) $display("FAIL async_reset_idle got quiet=%b writes=%0d required quiet=1 writes=0", quiet, wr_count - base);
    else n_pass++;
    for (int n = 0; n < 256; n++) begin
      n_checks++;
      if (c_mem[swp(n[7:0])] !== ((n < 48) ? a_mem[n] : 32'hDEADBEEF))
        $display("FAIL async_partial_c_%0d got=%h required=%h", swp(n[7:0]), c_mem[swp(n[7:0])],
                 (n < 48) ? a_mem[n] : 32'hDEADBEEF);
      else n_pass++;
    end
    push_expected();
    run_full(got_done);
    n_checks++;
    if (!got_done) $display("FAIL async_rerun_done got=timeout required=done");
    else n_pass++;
    for (int n = 0; n < 256; n++) begin
      n_checks++;
      if (c_mem[swp(n[7:0])] !== a_mem[n])
        $display("FAIL async_rerun_c_%0d got=%h required=%h", swp(n[7:0]), c_mem[swp(n[7:0])], a_mem[n]);
      else n_pass++;
    end
  endtask

  task automatic test_double_transpose();
    bit got_done;
    for (int n = 0; n < 256; n++) orig[n] = $urandom;
    orig[0]     = 32'hFFFFFFFF;
    orig[1]     = 32'h00000000;
    orig[8'h37] = 32'hFFFFFFFF;
    orig[255]   = 32'h00000000;
    for (int n = 0; n < 256; n++) a_mem[n] = orig[n];
    push_expected();
    run_full(got_done);
    n_checks++;
    if (!got_done) $display("FAIL double_pass1_done got=timeout required=done");
    else n_pass++;
    @(negedge clk);
    for (int n = 0; n < 256; n++) a_mem[n] = c_mem[n];
    fill_c(32'h12345678);
    push_expected();
    run_full(got_done);
    n_checks++;
    if (!got_done) $display("FAIL double_pass2_done got=timeout required=done");
    else n_pass++;
    for (int n = 0; n < 256; n++) begin
      n_checks++;
      if (c_mem[n] !== orig[n]) $display("FAIL double_c_%0d got=%h required=%h", n, c_mem[n], orig[n]);
      else n_pass++;
    end
    n_checks++;
    if (sb_addr.size() != 0) $display("FAIL double_sb_left got=%0d required=0", sb_addr.size());
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    t   = 1'b0;
    mem_if.Ai_p0_rd_data = '0;
    test_reset();
    test_identity_timing();
    test_retrigger();
    test_back_to_back();
    test_async_reset();
    test_double_transpose();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
